// File: rtl/rgb_pkg.sv
// Shared constants for the RGB receive path: default timing, word geometry
// and the in-band stream-reset marker.
package rgb_pkg;

  localparam int DEF_COUNTER_MAX       = 5000;
  localparam int DEF_STREAM_RESET_CLKS = 4800;
  localparam int DEF_SAMPLE_TIME_CLKS  = 57;
  localparam int DEF_DATA_SIZE         = 32;
  localparam int DEF_ADDR_SIZE         = 8;

  localparam int          RGB_WORD_BITS       = 24;
  localparam logic [31:0] STREAM_RESET_MARKER = 32'hFFFF_FFFF;

  // Zero-extends a GRB word so it can never collide with the marker.
  function automatic logic [31:0] pack_rgb(input logic [RGB_WORD_BITS-1:0] grb);
    return {8'h00, grb};
  endfunction

endpackage

// File: rtl/rgb_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers so that
// every entry is usable; writes while full are dropped and flagged.
module rgb_sync_fifo
  import rgb_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [DATA_SIZE-1:0] wr_data_i,
  input  logic                 rd_en_i,
  output logic [DATA_SIZE-1:0] rd_data_o,
  output logic                 rd_empty_o,
  output logic                 wr_full_o,
  output logic                 overflow_o
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem_q [0:DEPTH-1];
  logic [ADDR_SIZE:0]   wptr_q, wptr_d;
  logic [ADDR_SIZE:0]   rptr_q, rptr_d;
  logic                 overflow_q, overflow_d;
  logic                 full_s, empty_s, wr_ok_s, rd_ok_s;

  // Status and next pointers; full is judged on the pre-read pointers.
  always_comb begin
    full_s     = (wptr_q[ADDR_SIZE] != rptr_q[ADDR_SIZE]) &&
                 (wptr_q[ADDR_SIZE-1:0] == rptr_q[ADDR_SIZE-1:0]);
    empty_s    = (wptr_q == rptr_q);
    wr_ok_s    = wr_en_i && !full_s;
    rd_ok_s    = rd_en_i && !empty_s;
    wptr_d     = wr_ok_s ? wptr_q + {{ADDR_SIZE{1'b0}}, 1'b1} : wptr_q;
    rptr_d     = rd_ok_s ? rptr_q + {{ADDR_SIZE{1'b0}}, 1'b1} : rptr_q;
    overflow_d = overflow_q || (wr_en_i && full_s);
  end

  // Pointer and sticky overflow state.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are meaningless until the pointers cover them.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wptr_q[ADDR_SIZE-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o  = empty_s ? '0 : mem_q[rptr_q[ADDR_SIZE-1:0]];
  assign rd_empty_o = empty_s;
  assign wr_full_o  = full_s;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/rgb_input_path.sv
// WS2812-style serial receiver: synchronises the line, decodes pulse widths
// into GRB words and stream-reset markers, and queues them in a FIFO.
module rgb_input_path
  import rgb_pkg::*;
#(
  parameter int COUNTER_MAX       = DEF_COUNTER_MAX,
  parameter int STREAM_RESET_CLKS = DEF_STREAM_RESET_CLKS,
  parameter int SAMPLE_TIME_CLKS  = DEF_SAMPLE_TIME_CLKS,
  parameter int DATA_SIZE         = DEF_DATA_SIZE,
  parameter int ADDR_SIZE         = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_empty,
  output logic                 wr_full,
  output logic                 overflow
);

  localparam int CNT_W  = $clog2(COUNTER_MAX + 1);
  localparam int BCNT_W = $clog2(RGB_WORD_BITS);

  logic                     sig_meta_q, sig_s_q, sig_prev_q;
  logic [CNT_W-1:0]         hi_cnt_q, hi_cnt_d, hi_cnt_s;
  logic [CNT_W-1:0]         lo_cnt_q, lo_cnt_d;
  logic                     smp_arm_q, smp_arm_d, smp_arm_s;
  logic                     rst_arm_q, rst_arm_d;
  logic [RGB_WORD_BITS-2:0] shift_q, shift_d;
  logic [BCNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                     wr_en_q, wr_en_d;
  logic [DATA_SIZE-1:0]     wr_data_q, wr_data_d;
  logic                     rise_s, bit_stb_s, srst_evt_s;

  // Decode and assembly; the rising-edge cycle itself is count 0, so the
  // strobe lands exactly SAMPLE_TIME_CLKS cycles after sig_s first goes high.
  always_comb begin
    rise_s     = sig_s_q && !sig_prev_q;
    hi_cnt_s   = rise_s ? '0 : hi_cnt_q;
    smp_arm_s  = rise_s || smp_arm_q;
    bit_stb_s  = smp_arm_s && (hi_cnt_s == CNT_W'(SAMPLE_TIME_CLKS));
    hi_cnt_d   = (hi_cnt_s == CNT_W'(COUNTER_MAX)) ? hi_cnt_s : hi_cnt_s + CNT_W'(1);
    smp_arm_d  = smp_arm_s && !bit_stb_s;
    lo_cnt_d   = sig_s_q ? '0 :
                 ((lo_cnt_q == CNT_W'(COUNTER_MAX)) ? lo_cnt_q : lo_cnt_q + CNT_W'(1));
    srst_evt_s = !sig_s_q && rst_arm_q && (lo_cnt_q == CNT_W'(STREAM_RESET_CLKS));
    rst_arm_d  = sig_s_q || (rst_arm_q && !srst_evt_s);
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    if (srst_evt_s) begin
      shift_d   = '0;
      bit_cnt_d = '0;
      wr_en_d   = 1'b1;
      wr_data_d = DATA_SIZE'(STREAM_RESET_MARKER);
    end else if (bit_stb_s) begin
      shift_d = {shift_q[RGB_WORD_BITS-3:0], sig_s_q};
      if (bit_cnt_q == BCNT_W'(RGB_WORD_BITS - 1)) begin
        bit_cnt_d = '0;
        wr_en_d   = 1'b1;
        wr_data_d = DATA_SIZE'(pack_rgb({shift_q, sig_s_q}));
      end else begin
        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
      end
    end else begin
      shift_d = shift_q;
    end
  end

  // Synchroniser, counters, shift register and registered FIFO write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_meta_q <= 1'b0;
      sig_s_q    <= 1'b0;
      sig_prev_q <= 1'b0;
      hi_cnt_q   <= '0;
      lo_cnt_q   <= '0;
      smp_arm_q  <= 1'b0;
      rst_arm_q  <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      sig_meta_q <= sig;
      sig_s_q    <= sig_meta_q;
      sig_prev_q <= sig_s_q;
      hi_cnt_q   <= hi_cnt_d;
      lo_cnt_q   <= lo_cnt_d;
      smp_arm_q  <= smp_arm_d;
      rst_arm_q  <= rst_arm_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
    end
  end

  rgb_sync_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_fifo (
    .clk        (clk),
    .rst_ni     (rst),
    .wr_en_i    (wr_en_q),
    .wr_data_i  (wr_data_q),
    .rd_en_i    (rd_en),
    .rd_data_o  (rd_data),
    .rd_empty_o (rd_empty),
    .wr_full_o  (wr_full),
    .overflow_o (overflow)
  );

endmodule

// File: tb/tb_rgb_input_path.sv
// Scoreboard bench: one instance at nominal timing, one with shortened timing
// constants so the 256-deep fill and overflow cases stay short.
module tb_rgb_input_path;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sig_drv, rd_en_drv, fast_sel;
  logic        sig_d, sig_f, rd_en_d, rd_en_f;
  logic [31:0] rd_data_d, rd_data_f, rd_data_m;
  logic        rd_empty_d, rd_empty_f, rd_empty_m;
  logic        wr_full_d, wr_full_f, wr_full_m;
  logic        overflow_d, overflow_f, overflow_m;

  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  assign sig_d      = fast_sel ? 1'b0 : sig_drv;
  assign sig_f      = fast_sel ? sig_drv : 1'b0;
  assign rd_en_d    = fast_sel ? 1'b0 : rd_en_drv;
  assign rd_en_f    = fast_sel ? rd_en_drv : 1'b0;
  assign rd_data_m  = fast_sel ? rd_data_f : rd_data_d;
  assign rd_empty_m = fast_sel ? rd_empty_f : rd_empty_d;
  assign wr_full_m  = fast_sel ? wr_full_f : wr_full_d;
  assign overflow_m = fast_sel ? overflow_f : overflow_d;

  rgb_input_path dut (
    .clk(clk), .rst(rst), .sig(sig_d), .rd_en(rd_en_d),
    .rd_data(rd_data_d), .rd_empty(rd_empty_d), .wr_full(wr_full_d), .overflow(overflow_d)
  );

  rgb_input_path #(
    .COUNTER_MAX(2047), .STREAM_RESET_CLKS(2000), .SAMPLE_TIME_CLKS(5),
    .DATA_SIZE(32), .ADDR_SIZE(8)
  ) dut_f (
    .clk(clk), .rst(rst), .sig(sig_f), .rd_en(rd_en_f),
    .rd_data(rd_data_f), .rd_empty(rd_empty_f), .wr_full(wr_full_f), .overflow(overflow_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    int hi, lo;
    if (fast_sel) begin
      hi = b ? 7 : 3;
      lo = b ? 2 : 3;
    end else begin
      hi = b ? 62 : 52;
      lo = b ? 28 : 67;
    end
    sig_drv = 1'b1;
    idle(hi);
    sig_drv = 1'b0;
    idle(lo);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sig_drv = 1'b0;
    rd_en_drv = 1'b0;
    idle(2);
    rst = 1'b1;
    exp_q.delete();
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    n_vec++;
    if (rd_empty_m !== 1'b1) begin n_err++; $display("FAIL %s_empty: got %b want 1", tag, rd_empty_m); end
    n_vec++;
    if (wr_full_m !== 1'b0) begin n_err++; $display("FAIL %s_full: got %b want 0", tag, wr_full_m); end
    n_vec++;
    if (overflow_m !== 1'b0) begin n_err++; $display("FAIL %s_ovf: got %b want 0", tag, overflow_m); end
    n_vec++;
    if (rd_data_m !== 32'h0) begin n_err++; $display("FAIL %s_data: got %h want 00000000", tag, rd_data_m); end
  endtask

  // Pops every expected word, then requires the FIFO to be empty.
  task automatic drain(input string tag);
    logic [31:0] exp;
    int budget;
    while (exp_q.size() > 0) begin
      budget = 0;
      while (rd_empty_m && budget < 200) begin
        tick();
        budget++;
      end
      exp = exp_q.pop_front();
      n_vec++;
      if (rd_data_m !== exp) begin
        n_err++;
        $display("FAIL %s: rd_data=%h expected %h (empty=%b)", tag, rd_data_m, exp, rd_empty_m);
      end
      rd_en_drv = 1'b1;
      tick();
      rd_en_drv = 1'b0;
    end
    n_vec++;
    if (rd_empty_m !== 1'b1) begin
      n_err++;
      $display("FAIL %s_extra: rd_empty=%b expected 1, head %h", tag, rd_empty_m, rd_data_m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    check_idle_outputs("reset");
    rst = 1'b1;
    tick();
  endtask

  task automatic test_bit_decode();
    send_word(24'h00FF00);
    exp_q.push_back(32'h0000FF00);
    idle(4);
    drain("decode");
  endtask

  task automatic test_stream_reset();
    exp_q.push_back(32'hFFFF_FFFF);
    idle(4900);
    drain("marker");
    idle(10000);
    n_vec++;
    if (rd_empty_m !== 1'b1) begin
      n_err++;
      $display("FAIL marker_once: rd_empty=%b want 1, head %h", rd_empty_m, rd_data_m);
    end
  endtask

  task automatic test_partial_word();
    logic [23:0] part;
    part = 24'h5A5A5A;
    for (int i = 23; i >= 12; i--) send_bit(part[i]);
    exp_q.push_back(32'hFFFF_FFFF);
    idle(4900);
    send_word(24'hABCDEF);
    exp_q.push_back(32'h00ABCDEF);
    idle(4);
    drain("partial");
  endtask

  task automatic test_fill_overflow();
    logic [23:0] w;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'h00, 8'(i)};
      send_word(w);
      exp_q.push_back({8'h00, w});
      if (i == 254) begin
        idle(6);
        n_vec++;
        if (wr_full_m !== 1'b0) begin n_err++; $display("FAIL full_at_255: got %b want 0", wr_full_m); end
      end
    end
    idle(6);
    n_vec++;
    if (wr_full_m !== 1'b1) begin n_err++; $display("FAIL full_at_256: got %b want 1", wr_full_m); end
    n_vec++;
    if (overflow_m !== 1'b0) begin n_err++; $display("FAIL ovf_at_256: got %b want 0", overflow_m); end
    send_word(24'hC0FFEE);
    idle(6);
    n_vec++;
    if (overflow_m !== 1'b1) begin n_err++; $display("FAIL ovf_at_257: got %b want 1", overflow_m); end
    n_vec++;
    if (wr_full_m !== 1'b1) begin n_err++; $display("FAIL full_at_257: got %b want 1", wr_full_m); end
    drain("fill");
  endtask

  task automatic test_reset_midword();
    logic [23:0] part;
    send_word(24'h123456);
    idle(6);
    n_vec++;
    if (rd_empty_m !== 1'b0) begin n_err++; $display("FAIL midrst_pre: rd_empty=%b want 0", rd_empty_m); end
    part = 24'hFEDCBA;
    for (int i = 23; i >= 12; i--) send_bit(part[i]);
    sig_drv = 1'b1;
    idle(3);
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    exp_q.delete();
    sig_drv = 1'b0;
    idle(2);
    rst = 1'b1;
    tick();
    send_word(24'h5A3C96);
    exp_q.push_back(32'h005A3C96);
    idle(6);
    drain("post_rst");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    do_reset();
    send_word(24'h111111);
    exp_q.push_back(32'h00111111);
    send_word(24'h2A2A2A);
    exp_q.push_back(32'h002A2A2A);
    send_word(24'h3C3C3C);
    exp_q.push_back(32'h003C3C3C);
    idle(6);
    rd_en_drv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp = exp_q.pop_front();
      n_vec++;
      if (rd_data_m !== exp || rd_empty_m !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_%0d: rd_data=%h empty=%b want %h", k, rd_data_m, rd_empty_m, exp);
      end
      tick();
    end
    n_vec++;
    if (rd_empty_m !== 1'b1 || rd_data_m !== 32'h0) begin
      n_err++;
      $display("FAIL b2b_end: empty=%b data=%h want 1/00000000", rd_empty_m, rd_data_m);
    end
    rd_en_drv = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    sig_drv = 1'b0;
    rd_en_drv = 1'b0;
    fast_sel = 1'b0;
    test_reset();
    test_bit_decode();
    test_stream_reset();
    test_partial_word();
    fast_sel = 1'b1;
    do_reset();
    test_fill_overflow();
    test_reset_midword();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
